ctrl_rst_seq: RTL and testbench



---
 rtl/ctrl_rst_seq.sv | 157 +++++++++++++++
 tb/tb_ctrl_rst_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_rst_seq.sv
// Reset release sequencer for the ctrl clock generator domains (50 MHz).
// Qualifies DCM lock, then releases memory, control CPU and system core resets in turn.
module ctrl_rst_seq #(
  parameter int CW        = 16,
  parameter int LOCK_CYC  = 1024,
  parameter int STAGE_CYC = 256,
  parameter int SWRST_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       mem_ready,
  input  logic       sw_rst_req,
  output logic       rst_mem,
  output logic       rst_ctrl,
  output logic       rst_sys,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    REL_MEM     = 3'd2,
    REL_CTRL    = 3'd3,
    RUN         = 3'd4,
    SWRST       = 3'd5
  } state_t;

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYC - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYC - 1);
  localparam logic [CW-1:0] SWRST_LAST = CW'(SWRST_CYC - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          cnt_clr;
  logic          lock_lost;
  logic          sync_meta;
  logic          locked_s;
  logic          rst_mem_d;
  logic          rst_ctrl_d;
  logic          rst_sys_d;
  logic          ready_d;

  // pll_locked comes from the DCM with no timing relation to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      locked_s  <= sync_meta;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    lock_lost = 1'b0;
    if (state_q != WAIT_LOCK && !locked_s) begin
      state_d   = WAIT_LOCK;
      lock_lost = (state_q == RUN) || (state_q == SWRST);
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (locked_s) state_d = LOCK_STABLE;
        end
        LOCK_STABLE: begin
          if (cnt == LOCK_LAST) state_d = REL_MEM;
        end
        REL_MEM: begin
          if (mem_ready || cnt == STAGE_LAST) state_d = REL_CTRL;
        end
        REL_CTRL: begin
          if (cnt == STAGE_LAST) state_d = RUN;
        end
        RUN: begin
          if (sw_rst_req) state_d = SWRST;
        end
        SWRST: begin
          // A fresh request restarts the pulse even on its last cycle.
          if (sw_rst_req) cnt_clr = 1'b1;
          else if (cnt == SWRST_LAST) state_d = RUN;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt;
    if (state_d != state_q || cnt_clr) begin
      cnt_d = '0;
    end else if (state_q == LOCK_STABLE || state_q == REL_MEM ||
                 state_q == REL_CTRL || state_q == SWRST) begin
      cnt_d = cnt + CW'(1);
    end
  end

  // Outputs are decoded from the next state so they move with the transition.
  always_comb begin
    rst_mem_d  = 1'b1;
    rst_ctrl_d = 1'b1;
    rst_sys_d  = 1'b1;
    ready_d    = 1'b0;
    case (state_d)
      REL_MEM: begin
        rst_mem_d = 1'b0;
      end
      REL_CTRL: begin
        rst_mem_d  = 1'b0;
        rst_ctrl_d = 1'b0;
      end
      RUN: begin
        rst_mem_d  = 1'b0;
        rst_ctrl_d = 1'b0;
        rst_sys_d  = 1'b0;
        ready_d    = 1'b1;
      end
      SWRST: begin
        rst_mem_d  = 1'b0;
        rst_ctrl_d = 1'b0;
      end
      default: begin
        rst_mem_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      cnt           <= '0;
      rst_mem       <= 1'b1;
      rst_ctrl      <= 1'b1;
      rst_sys       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt      <= cnt_d;
      rst_mem  <= rst_mem_d;
      rst_ctrl <= rst_ctrl_d;
      rst_sys  <= rst_sys_d;
      ready    <= ready_d;
      if (lock_lost && lock_loss_cnt != 8'hFF) begin
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_rst_seq.sv
// Scoreboard bench for ctrl_rst_seq: a cycle-level reference model queues expected outputs,
// a monitor compares them one cycle at a time; directed scenarios plus randomized traffic.
module tb_ctrl_rst_seq;

  localparam int LOCK_CYC  = 8;
  localparam int STAGE_CYC = 4;
  localparam int SWRST_CYC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       mem_ready;
  logic       sw_rst_req;
  logic       rst_mem;
  logic       rst_ctrl;
  logic       rst_sys;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  ctrl_rst_seq #(
    .CW(16), .LOCK_CYC(LOCK_CYC), .STAGE_CYC(STAGE_CYC), .SWRST_CYC(SWRST_CYC)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .mem_ready(mem_ready),
    .sw_rst_req(sw_rst_req), .rst_mem(rst_mem), .rst_ctrl(rst_ctrl),
    .rst_sys(rst_sys), .ready(ready), .state(state), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_mem;
    logic       rst_ctrl;
    logic       rst_sys;
    logic       ready;
    logic [2:0] state;
    logic [7:0] lcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase 0..5 = waiting, qualifying, mem, ctrl, running, sw reset.
  // m_left counts remaining cycles in a timed phase; losses is uncapped.
  int m_phase, m_left, m_losses;
  bit m_s1, m_s2;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_losses = 0; m_s1 = 0; m_s2 = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rst_mem  = (m_phase < 2);
    e.rst_ctrl = (m_phase < 3);
    e.rst_sys  = (m_phase != 4);
    e.ready    = (m_phase == 4);
    e.state    = 3'(m_phase);
    e.lcnt     = 8'((m_losses > 255) ? 255 : m_losses);
    return e;
  endfunction

  task automatic model_step(input bit pl, input bit mr, input bit sw);
    bit ls;
    ls = m_s2;
    if (m_phase != 0 && !ls) begin
      if (m_phase >= 4) m_losses++;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (ls) begin m_phase = 1; m_left = LOCK_CYC; end
        1: begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_left = STAGE_CYC; end
        end
        2: begin
          if (!mr) m_left--;
          if (mr || m_left == 0) begin m_phase = 3; m_left = STAGE_CYC; end
        end
        3: begin
          m_left--;
          if (m_left == 0) m_phase = 4;
        end
        4: if (sw) begin m_phase = 5; m_left = SWRST_CYC; end
        5: begin
          if (sw) m_left = SWRST_CYC;
          else begin
            m_left--;
            if (m_left == 0) m_phase = 4;
          end
        end
        default: m_phase = 0;
      endcase
    end
    m_s2 = m_s1;
    m_s1 = pl;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a = {rst_mem, rst_ctrl, rst_sys, ready, state, lock_loss_cnt};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual mem=%b ctrl=%b sys=%b ready=%b state=%0d lcnt=%0d required mem=%b ctrl=%b sys=%b ready=%b state=%0d lcnt=%0d",
               name, $time, a.rst_mem, a.rst_ctrl, a.rst_sys, a.ready, a.state, a.lcnt,
               e.rst_mem, e.rst_ctrl, e.rst_sys, e.ready, e.state, e.lcnt);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock cycle of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic applyStimulus(input bit pl, input bit mr, input bit sw);
    @(negedge clk);
    rst = 1'b0; pll_locked = pl; mem_ready = mr; sw_rst_req = sw;
    model_step(pl, mr, sw);
    exp_q.push_back(model_out());
  endtask

  // Reset is raised between edges so its effect must show without a clock.
  task automatic applyReset(input bit pl);
    @(negedge clk);
    rst = 1'b1; pll_locked = pl; mem_ready = 1'b0; sw_rst_req = 1'b0;
    model_reset();
    #1 checkOutput("async_reset", model_out());
    exp_q.push_back(model_out());
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) checkOutput("cycle", exp_q.pop_front());
  end

  initial begin
    int f_mem, f_ctrl, f_sys, guard;
    rst = 1'b1; pll_locked = 1'b0; mem_ready = 1'b0; sw_rst_req = 1'b0;
    model_reset();
    #2 checkOutput("reset_state", model_out());

    // Scenario 1: edge 0 is the edge whose cycle raises pll_locked.
    repeat (3) applyStimulus(0, 0, 0);
    f_mem = -1; f_ctrl = -1; f_sys = -1;
    for (int e = 1; e <= 22; e++) begin
      applyStimulus(1, 0, 0);
      @(posedge clk); #2;
      if (!rst_mem && f_mem < 0) f_mem = e;
      if (!rst_ctrl && f_ctrl < 0) f_ctrl = e;
      if (!rst_sys && ready && f_sys < 0) f_sys = e;
    end
    checkValue("s1_mem_release_edge", f_mem, 11);
    checkValue("s1_ctrl_release_edge", f_ctrl, 15);
    checkValue("s1_sys_release_edge", f_sys, 19);

    // Scenario 2: mem_ready cuts the memory stage short.
    applyReset(0);
    repeat (2) applyStimulus(0, 0, 0);
    f_ctrl = -1; f_sys = -1;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1, (e == 13), 0);
      @(posedge clk); #2;
      if (!rst_ctrl && f_ctrl < 0) f_ctrl = e;
      if (!rst_sys && f_sys < 0) f_sys = e;
    end
    checkValue("s2_ctrl_release_edge", f_ctrl, 13);
    checkValue("s2_sys_release_edge", f_sys, 17);

    // Scenario 3: short lock dropout while qualifying.
    applyReset(0);
    repeat (7) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    repeat (25) applyStimulus(1, 0, 0);
    @(posedge clk); #2;
    checkValue("s3_lock_loss_cnt", lock_loss_cnt, 0);
    checkValue("s3_ready", ready, 1);

    // Scenario 4: software reset, then an extending request.
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    repeat (6) applyStimulus(1, 0, 0);

    // Scenario 5: lock loss beats a simultaneous sw request; counter saturates.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 1);
      if (i == 0) begin
        @(posedge clk); #2;
        checkValue("s5_first_loss_cnt", lock_loss_cnt, 1);
      end
      repeat (18) applyStimulus(1, 0, 0);
    end
    @(posedge clk); #2;
    checkValue("s5_saturated_cnt", lock_loss_cnt, 255);

    // Scenario 6: reset in the middle of the ctrl release stage.
    applyStimulus(0, 0, 0);
    guard = 0;
    while (m_phase != 3 && guard < 60) begin
      applyStimulus(1, 0, 0);
      guard++;
    end
    checkValue("s6_reached_rel_ctrl", m_phase, 3);
    applyReset(1);
    f_mem = -1;
    for (int e = 1; e <= 15; e++) begin
      applyStimulus(1, 0, 0);
      @(posedge clk); #2;
      if (!rst_mem && f_mem < 0) f_mem = e;
    end
    checkValue("s6_restart_mem_edge", f_mem, 11);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) applyReset($urandom_range(1));
      else applyStimulus($urandom_range(39) != 0, $urandom_range(5) == 0,
                         $urandom_range(7) == 0);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk); #2;
      guard++;
    end
    checkValue("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
